// File: rtl/board_io_ctrl.sv
// board_io_ctrl: register-mapped LED/button/switch block with debounce, event irq and LED blink
module board_io_ctrl #(
  parameter int N_LED = 8,
  parameter int N_BTN = 5,
  parameter int N_SW = 8,
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W = 16,
  parameter int BLINK_W = 24,
  parameter logic [BLINK_W-1:0] BLINK_DEFAULT = 24'd5000000
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_SW-1:0]  sw_in,
  output logic [N_LED-1:0] led_out,
  input  logic [2:0]       reg_addr,
  input  logic             reg_wr,
  input  logic             reg_rd,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             reg_ack,
  output logic             irq
);
  localparam int N_EVT = N_BTN + N_SW;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  logic [N_BTN-1:0] btn_s1, btn_s2, btn_stable, btn_accept;
  logic [N_SW-1:0] sw_s1, sw_s2, sw_prev;
  logic [DEB_W-1:0] btn_cnt [N_BTN];
  logic [N_LED-1:0] led_data, led_mode;
  logic [N_EVT-1:0] evt_stat, evt_mask, evt_set, evt_clr;
  logic [BLINK_W-1:0] blink, blink_cnt;
  logic phase, blink_wrap;
  logic [1:0] settle;
  logic [31:0] rmap [8];
  logic wr_led, wr_mode, wr_evt, wr_mask, wr_blink;
  logic unused_wdata;
  assign unused_wdata = ^reg_wdata;
  assign wr_led = reg_wr && reg_addr == 3'd0;
  assign wr_mode = reg_wr && reg_addr == 3'd1;
  assign wr_evt = reg_wr && reg_addr == 3'd4;
  assign wr_mask = reg_wr && reg_addr == 3'd5;
  assign wr_blink = reg_wr && reg_addr == 3'd6;
  assign blink_wrap = blink_cnt == blink;
  always_comb begin
    for (int i = 0; i < N_BTN; i++)
      btn_accept[i] = btn_s2[i] != btn_stable[i] && btn_cnt[i] == DEB_LAST;
  end
  // events stay off until the synchronisers have flushed their reset contents
  assign evt_set = settle == 2'd3 ? {sw_s2 ^ sw_prev, btn_accept & btn_s2} : '0;
  assign evt_clr = wr_evt ? reg_wdata[N_EVT-1:0] : '0;
  always_comb begin
    rmap[0] = 32'(led_data);
    rmap[1] = 32'(led_mode);
    rmap[2] = 32'(btn_stable);
    rmap[3] = 32'(sw_s2);
    rmap[4] = 32'(evt_stat);
    rmap[5] = 32'(evt_mask);
    rmap[6] = 32'(blink);
    rmap[7] = '0;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      btn_stable <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
      sw_prev <= '0;
      settle <= '0;
      for (int i = 0; i < N_BTN; i++) btn_cnt[i] <= '0;
    end else begin
      btn_s1 <= btn_in;
      btn_s2 <= btn_s1;
      sw_s1 <= sw_in;
      sw_s2 <= sw_s1;
      sw_prev <= sw_s2;
      settle <= settle == 2'd3 ? settle : settle + 2'd1;
      btn_stable <= btn_stable ^ btn_accept;
      for (int i = 0; i < N_BTN; i++)
        btn_cnt[i] <= (btn_s2[i] == btn_stable[i] || btn_accept[i]) ? '0 : btn_cnt[i] + DEB_W'(1);
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      led_data <= '0;
      led_mode <= '0;
      evt_mask <= '0;
      evt_stat <= '0;
    end else begin
      if (wr_led) led_data <= reg_wdata[N_LED-1:0];
      if (wr_mode) led_mode <= reg_wdata[N_LED-1:0];
      if (wr_mask) evt_mask <= reg_wdata[N_EVT-1:0];
      evt_stat <= (evt_stat & ~evt_clr) | evt_set;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      blink <= BLINK_DEFAULT;
      blink_cnt <= '0;
      phase <= 1'b1;
    end else if (wr_blink) begin
      blink <= reg_wdata[BLINK_W-1:0];
      blink_cnt <= '0;
      phase <= 1'b1;
    end else begin
      blink_cnt <= blink_wrap ? '0 : blink_cnt + BLINK_W'(1);
      phase <= phase ^ blink_wrap;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      reg_ack <= 1'b0;
      reg_rdata <= '0;
      irq <= 1'b0;
      led_out <= '0;
    end else begin
      reg_ack <= reg_wr | reg_rd;
      reg_rdata <= (reg_rd && !reg_wr) ? rmap[reg_addr] : '0;
      irq <= |(evt_stat & evt_mask);
      led_out <= led_data & (~led_mode | {N_LED{phase}});
    end
  end
endmodule

// File: tb/tb_board_io_ctrl.sv
// tb_board_io_ctrl: directed and randomized checks of board_io_ctrl against a behavioural model
module tb_board_io_ctrl;
  localparam int N_LED = 8;
  localparam int N_BTN = 5;
  localparam int N_SW = 8;
  localparam int DEB = 16;
  localparam int N_EVT = N_BTN + N_SW;
  logic clk = 1'b0;
  logic sys_rst;
  logic [N_BTN-1:0] btn_in;
  logic [N_SW-1:0] sw_in;
  logic [N_LED-1:0] led_out;
  logic [2:0] reg_addr;
  logic reg_wr, reg_rd, reg_ack, irq;
  logic [31:0] reg_wdata, reg_rdata;
  int n_tests = 0;
  int n_fail = 0;
  board_io_ctrl #(.N_LED(N_LED), .N_BTN(N_BTN), .N_SW(N_SW), .DEB_CYCLES(DEB), .DEB_W(5), .BLINK_W(24)) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .btn_in(btn_in), .sw_in(sw_in), .led_out(led_out),
    .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .irq(irq)
  );
  always #5 clk = ~clk;
  // model state: sync pipes, run length of each synchronised button level, cycles since blink restart
  logic [N_BTN-1:0] mb1, mb2, mstable, mlast;
  int mrun [N_BTN];
  logic [N_SW-1:0] ms1, ms2, msw_prev;
  logic [N_LED-1:0] mled_data, mled_mode, m_led;
  logic [N_EVT-1:0] mevt, mmask;
  int mblink, mk, msettle;
  logic m_ack, m_irq;
  logic [31:0] m_rdata;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step_model();
    logic [N_EVT-1:0] set, clr;
    logic [N_BTN-1:0] press;
    logic [N_SW-1:0] chg;
    logic [31:0] rd_val;
    logic ph;
    if (sys_rst) begin
      mb1 = '0; mb2 = '0; mstable = '0; mlast = '0;
      ms1 = '0; ms2 = '0; msw_prev = '0;
      mled_data = '0; mled_mode = '0; mevt = '0; mmask = '0;
      mblink = 5000000; mk = 0; msettle = 0;
      m_ack = 1'b0; m_rdata = '0; m_irq = 1'b0; m_led = '0;
      for (int i = 0; i < N_BTN; i++) mrun[i] = 0;
      return;
    end
    case (reg_addr)
      3'd0: rd_val = 32'(mled_data);
      3'd1: rd_val = 32'(mled_mode);
      3'd2: rd_val = 32'(mstable);
      3'd3: rd_val = 32'(ms2);
      3'd4: rd_val = 32'(mevt);
      3'd5: rd_val = 32'(mmask);
      3'd6: rd_val = 32'(mblink);
      default: rd_val = '0;
    endcase
    ph = ((mk / (mblink + 1)) % 2) == 0;
    m_led = mled_data & (~mled_mode | {N_LED{ph}});
    m_ack = reg_wr | reg_rd;
    m_rdata = (reg_rd && !reg_wr) ? rd_val : '0;
    m_irq = |(mevt & mmask);
    press = '0;
    for (int i = 0; i < N_BTN; i++) begin
      mrun[i] = (mb2[i] == mlast[i]) ? mrun[i] + 1 : 1;
      mlast[i] = mb2[i];
      if (mb2[i] != mstable[i] && mrun[i] >= DEB) begin
        mstable[i] = mb2[i];
        press[i] = mb2[i];
      end
    end
    chg = ms2 ^ msw_prev;
    msw_prev = ms2;
    set = (msettle >= 3) ? {chg, press} : '0;
    msettle = msettle < 3 ? msettle + 1 : 3;
    clr = (reg_wr && reg_addr == 3'd4) ? reg_wdata[N_EVT-1:0] : '0;
    mevt = (mevt & ~clr) | set;
    mb2 = mb1; mb1 = btn_in;
    ms2 = ms1; ms1 = sw_in;
    mk = mk + 1;
    if (reg_wr) begin
      if (reg_addr == 3'd0) mled_data = reg_wdata[N_LED-1:0];
      if (reg_addr == 3'd1) mled_mode = reg_wdata[N_LED-1:0];
      if (reg_addr == 3'd5) mmask = reg_wdata[N_EVT-1:0];
      if (reg_addr == 3'd6) begin
        mblink = int'(reg_wdata[23:0]);
        mk = 0;
      end
    end
  endtask
  task automatic cycle();
    step_model();
    @(negedge clk);
    check("ack", 32'(reg_ack), 32'(m_ack));
    check("rdata", reg_rdata, m_rdata);
    check("irq", 32'(irq), 32'(m_irq));
    check("led", 32'(led_out), 32'(m_led));
  endtask
  task automatic idle(input int n);
    repeat (n) cycle();
  endtask
  task automatic bus(input logic wr, input logic rd, input logic [2:0] a, input logic [31:0] d);
    reg_wr = wr; reg_rd = rd; reg_addr = a; reg_wdata = d;
    cycle();
    reg_wr = 1'b0; reg_rd = 1'b0;
  endtask
  initial begin
    int b;
    sys_rst = 1'b1; btn_in = '0; sw_in = 8'hA5;
    reg_addr = '0; reg_wr = 1'b0; reg_rd = 1'b0; reg_wdata = '0;
    idle(3);
    sys_rst = 1'b0;
    idle(5);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_led", 32'(led_out), 32'h0);
    bus(0, 1, 3'd3, 0);
    check("sw_ack", 32'(reg_ack), 32'h1);
    check("sw_state", reg_rdata, 32'hA5);
    bus(0, 1, 3'd4, 0);
    check("evt_rst", reg_rdata, 32'h0);
    bus(0, 1, 3'd6, 0);
    check("blink_rst", reg_rdata, 32'd5000000);
    btn_in[2] = 1'b1;
    idle(17);
    bus(0, 1, 3'd2, 0);
    check("btn_pre", reg_rdata, 32'h0);
    bus(0, 1, 3'd2, 0);
    check("btn_18", reg_rdata, 32'h4);
    bus(0, 1, 3'd4, 0);
    check("press_evt", reg_rdata, 32'h4);
    idle(8);
    btn_in[2] = 1'b0;
    idle(25);
    bus(0, 1, 3'd2, 0);
    check("btn_release", reg_rdata, 32'h0);
    bus(1, 0, 3'd4, 32'h1FFF);
    btn_in[2] = 1'b1;
    idle(10);
    btn_in[2] = 1'b0;
    idle(25);
    bus(0, 1, 3'd2, 0);
    check("glitch_state", reg_rdata, 32'h0);
    bus(0, 1, 3'd4, 0);
    check("glitch_evt", reg_rdata, 32'h0);
    bus(1, 0, 3'd5, 32'h4);
    btn_in[2] = 1'b1;
    idle(17);
    cycle();
    check("irq_lag", 32'(irq), 32'h0);
    cycle();
    check("irq_set", 32'(irq), 32'h1);
    bus(1, 0, 3'd4, 32'h4);
    check("irq_hold", 32'(irq), 32'h1);
    cycle();
    check("irq_clr", 32'(irq), 32'h0);
    btn_in[2] = 1'b0;
    idle(25);
    btn_in[2] = 1'b1;
    idle(17);
    bus(1, 0, 3'd4, 32'h4);
    bus(0, 1, 3'd4, 0);
    check("w1c_race", reg_rdata, 32'h4);
    btn_in[2] = 1'b0;
    idle(25);
    bus(1, 0, 3'd0, 32'hFF);
    bus(1, 0, 3'd1, 32'h0F);
    bus(1, 0, 3'd6, 32'd3);
    for (int i = 1; i <= 12; i++) begin
      cycle();
      check("blink_led", 32'(led_out), ((i - 1) / 4) % 2 == 0 ? 32'hFF : 32'hF0);
    end
    bus(1, 1, 3'd0, 32'h3C);
    check("wr_rd_ack", 32'(reg_ack), 32'h1);
    check("wr_rd_rdata", reg_rdata, 32'h0);
    cycle();
    check("ack_once", 32'(reg_ack), 32'h0);
    bus(0, 1, 3'd0, 0);
    check("led_rb", reg_rdata, 32'h3C);
    bus(0, 1, 3'd3, 0);
    check("pre_rst_ack", 32'(reg_ack), 32'h1);
    sys_rst = 1'b1;
    cycle();
    check("rst_ack", 32'(reg_ack), 32'h0);
    check("rst_led_mid", 32'(led_out), 32'h0);
    idle(2);
    sys_rst = 1'b0;
    idle(5);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        b = $urandom_range(0, N_BTN - 1);
        btn_in[b] = ~btn_in[b];
      end
      if ($urandom_range(0, 19) == 0) begin
        b = $urandom_range(0, N_SW - 1);
        sw_in[b] = ~sw_in[b];
      end
      if ($urandom_range(0, 9) < 3) begin
        reg_addr = 3'($urandom_range(0, 7));
        reg_wr = 1'($urandom_range(0, 1));
        reg_rd = reg_wr ? ($urandom_range(0, 3) == 0) : 1'b1;
        reg_wdata = reg_addr == 3'd6 ? 32'($urandom_range(0, 7)) : $urandom;
      end else begin
        reg_wr = 1'b0;
        reg_rd = 1'b0;
      end
      sys_rst = n == 1500;
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
